// File: rtl/cdu_counter_bank.sv
// N-channel CDU read-counter bank with pending-pulse accumulators,
// saturating error counters and a round-robin pulse bus to the AGC.
module cdu_counter_bank #(
  parameter int NCHAN     = 5,
  parameter int WIDTH     = 16,
  parameter int PEND_W    = 4,
  parameter int ERR_WIDTH = 9,
  parameter int CHW       = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       faz_stb,
  input  logic [NCHAN-1:0]           up_req,
  input  logic [NCHAN-1:0]           dn_req,
  input  logic [NCHAN-1:0]           cduz,
  input  logic [NCHAN-1:0]           ca,
  input  logic [NCHAN*WIDTH-1:0]     ca_value,
  input  logic [NCHAN-1:0]           eec,
  input  logic [NCHAN-1:0]           agc_pcnt,
  input  logic [NCHAN-1:0]           agc_mcnt,
  output logic [NCHAN*WIDTH-1:0]     cnt_flat,
  output logic [NCHAN*ERR_WIDTH-1:0] err_flat,
  output logic [NCHAN-1:0]           pend_ovf,
  output logic                       pulse_valid,
  output logic [CHW-1:0]             pulse_chan,
  output logic                       pulse_dir
);

  localparam int NSLOT = 1 << CHW;
  localparam logic [CHW:0] NCH_W = (CHW+1)'(NCHAN);
  localparam logic signed [PEND_W+1:0] PLIM =
    (PEND_W+2)'((1 << (PEND_W-1)) - 1);
  localparam logic signed [ERR_WIDTH-1:0] EMAX =
    ERR_WIDTH'((1 << (ERR_WIDTH-1)) - 1);

  // Per-channel arbiter inputs: eligible for a grant, and pend sign.
  logic [NCHAN-1:0] elig;
  logic [NCHAN-1:0] pos;
  logic [NCHAN-1:0] gnt;

  logic [NSLOT-1:0] elig_ext;
  logic [NSLOT-1:0] pos_ext;
  logic [CHW:0]     probe;
  logic             hit;
  logic [CHW-1:0]   gnt_idx;
  logic             gnt_dir;
  logic [CHW-1:0]   ptr_q;

  // Round-robin search from ptr+1 on a strobe; first eligible wins.
  always_comb begin
    elig_ext = '0;
    pos_ext  = '0;
    elig_ext[NCHAN-1:0] = elig;
    pos_ext[NCHAN-1:0]  = pos;
    hit     = 1'b0;
    gnt_idx = ptr_q;
    probe   = '0;
    if (faz_stb) begin
      for (int k = 1; k <= NCHAN; k++) begin
        probe = {1'b0, ptr_q} + (CHW+1)'(k);
        if (probe >= NCH_W)
          probe = probe - NCH_W;
        if (!hit && elig_ext[probe[CHW-1:0]]) begin
          hit     = 1'b1;
          gnt_idx = probe[CHW-1:0];
        end
      end
    end
    gnt_dir = pos_ext[gnt_idx];
  end

  // One-hot grant decoded from the winning index.
  always_comb begin
    gnt = '0;
    for (int i = 0; i < NCHAN; i++)
      gnt[i] = hit && (gnt_idx == CHW'(i));
  end

  // Pulse bus register and arbiter pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pulse_valid <= 1'b0;
      pulse_chan  <= '0;
      pulse_dir   <= 1'b0;
      ptr_q       <= CHW'(NCHAN-1);
    end else begin
      pulse_valid <= hit;
      if (hit) begin
        pulse_chan <= gnt_idx;
        pulse_dir  <= gnt_dir;
        ptr_q      <= gnt_idx;
      end
    end
  end

  for (genvar i = 0; i < NCHAN; i++) begin : g_ch
    logic [WIDTH-1:0]            cnt_q;
    logic signed [PEND_W-1:0]    pend_q;
    logic signed [ERR_WIDTH-1:0] err_q;
    logic                        ovf_q;
    logic                        up_only;
    logic                        dn_only;
    logic                        p_only;
    logic                        m_only;
    logic signed [PEND_W+1:0]    step;
    logic signed [PEND_W+1:0]    gstep;
    logic signed [PEND_W+1:0]    pend_nx;
    logic                        ovr;

    assign up_only = up_req[i] & ~dn_req[i];
    assign dn_only = dn_req[i] & ~up_req[i];
    assign p_only  = agc_pcnt[i] & ~agc_mcnt[i];
    assign m_only  = agc_mcnt[i] & ~agc_pcnt[i];

    assign elig[i] = (pend_q != '0) && !cduz[i] && !ca[i];
    assign pos[i]  = ~pend_q[PEND_W-1];

    // Net pending change: request step minus the granted pulse.
    always_comb begin
      step  = '0;
      gstep = '0;
      if (up_only)
        step = (PEND_W+2)'(1);
      else if (dn_only)
        step = '1;
      if (gnt[i])
        gstep = pos[i] ? (PEND_W+2)'(1) : '1;
      pend_nx = (PEND_W+2)'(pend_q) + step - gstep;
      ovr     = (pend_nx > PLIM) || (pend_nx < -PLIM);
    end

    // Read counter, pending accumulator and sticky overflow.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt_q  <= '0;
        pend_q <= '0;
        ovf_q  <= 1'b0;
      end else if (cduz[i]) begin
        cnt_q  <= '0;
        pend_q <= '0;
        ovf_q  <= 1'b0;
      end else if (ca[i]) begin
        cnt_q  <= ca_value[i*WIDTH +: WIDTH];
        pend_q <= '0;
      end else begin
        if (up_only)
          cnt_q <= cnt_q + WIDTH'(1);
        else if (dn_only)
          cnt_q <= cnt_q - WIDTH'(1);
        if (ovr)
          ovf_q <= 1'b1;
        else
          pend_q <= pend_nx[PEND_W-1:0];
      end
    end

    // Saturating error counter, held at zero while disabled.
    always_ff @(posedge clk or posedge rst) begin
      if (rst)
        err_q <= '0;
      else if (!eec[i])
        err_q <= '0;
      else if (p_only && err_q != EMAX)
        err_q <= err_q + ERR_WIDTH'(1);
      else if (m_only && err_q != -EMAX)
        err_q <= err_q - ERR_WIDTH'(1);
    end

    assign cnt_flat[i*WIDTH +: WIDTH]         = cnt_q;
    assign err_flat[i*ERR_WIDTH +: ERR_WIDTH] = err_q;
    assign pend_ovf[i]                        = ovf_q;
  end

endmodule

// File: tb/tb_cdu_counter_bank.sv
// Bench for cdu_counter_bank: directed scenarios with constant
// expectations plus a randomized run against a behavioural model.
module tb_cdu_counter_bank;

  localparam int N    = 5;
  localparam int W    = 16;
  localparam int PW   = 4;
  localparam int EW   = 9;
  localparam int CHW  = 4;
  localparam int L    = 7;
  localparam int EMAX = 255;

  logic           clk = 1'b0;
  logic           rst;
  logic           faz;
  logic [N-1:0]   up, dn, cz, ca, eec, pc, mc;
  logic [N*W-1:0] cav;
  logic [N*W-1:0] cnt_flat;
  logic [N*EW-1:0] err_flat;
  logic [N-1:0]   pend_ovf;
  logic           pv;
  logic [CHW-1:0] pch;
  logic           pdir;

  int nchk = 0;
  int nerr = 0;

  logic [W-1:0] m_cnt [N];
  int           m_pend [N];
  bit           m_ovf [N];
  int           m_err [N];
  int           m_ptr;
  bit           m_pv;
  int           m_pch;
  bit           m_pdir;

  cdu_counter_bank #(
    .NCHAN(N), .WIDTH(W), .PEND_W(PW), .ERR_WIDTH(EW), .CHW(CHW)
  ) dut (
    .clk(clk), .rst(rst), .faz_stb(faz),
    .up_req(up), .dn_req(dn), .cduz(cz), .ca(ca),
    .ca_value(cav), .eec(eec),
    .agc_pcnt(pc), .agc_mcnt(mc),
    .cnt_flat(cnt_flat), .err_flat(err_flat),
    .pend_ovf(pend_ovf), .pulse_valid(pv),
    .pulse_chan(pch), .pulse_dir(pdir)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, errors=%0d", nerr);
    $fatal(1, "watchdog");
  end

  function automatic int cnt_of(int i);
    return int'(cnt_flat[i*W +: W]);
  endfunction

  function automatic int err_of(int i);
    logic signed [EW-1:0] e;
    e = err_flat[i*EW +: EW];
    return int'(e);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_cnt[i] = '0; m_pend[i] = 0; m_ovf[i] = 0; m_err[i] = 0;
    end
    m_ptr = N-1; m_pv = 0; m_pch = 0; m_pdir = 0;
  endtask

  task automatic model_step();
    int g;
    int st;
    int gs;
    int np;
    bit gd;
    g = -1;
    gd = 0;
    if (faz)
      for (int k = 1; k <= N; k++) begin
        int j;
        j = (m_ptr + k) % N;
        if (g < 0 && m_pend[j] != 0 && !cz[j] && !ca[j]) g = j;
      end
    if (g >= 0) begin
      gd = m_pend[g] > 0;
      m_pv = 1; m_pch = g; m_pdir = gd; m_ptr = g;
    end else
      m_pv = 0;
    for (int i = 0; i < N; i++) begin
      st = (up[i] && !dn[i]) ? 1 : (dn[i] && !up[i]) ? -1 : 0;
      if (cz[i]) begin
        m_cnt[i] = '0; m_pend[i] = 0; m_ovf[i] = 0;
      end else if (ca[i]) begin
        m_cnt[i] = cav[i*W +: W]; m_pend[i] = 0;
      end else begin
        m_cnt[i] = m_cnt[i] + W'(st);
        gs = (i == g) ? (gd ? 1 : -1) : 0;
        np = m_pend[i] + st - gs;
        if (np > L || np < -L) m_ovf[i] = 1;
        else m_pend[i] = np;
      end
      if (!eec[i]) m_err[i] = 0;
      else if (pc[i] && !mc[i] && m_err[i] < EMAX) m_err[i]++;
      else if (mc[i] && !pc[i] && m_err[i] > -EMAX) m_err[i]--;
    end
  endtask

  task automatic clear_pulses();
    faz = 0; up = '0; dn = '0; cz = '0; ca = '0; pc = '0; mc = '0;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    clear_pulses();
  endtask

  task automatic do_reset();
    clear_pulses();
    eec = '0; cav = '0;
    rst = 1;
    model_reset();
    @(posedge clk);
    #1;
    rst = 0;
  endtask

  task automatic test_reset();
    up = '1; tick(); up = '1; tick();
    do_reset();
    for (int i = 0; i < N; i++) begin
      nchk++;
      if (cnt_of(i) !== 0) begin
        nerr++; $display("FAIL reset_cnt%0d: got %0d want 0", i, cnt_of(i));
      end
      nchk++;
      if (err_of(i) !== 0) begin
        nerr++; $display("FAIL reset_err%0d: got %0d want 0", i, err_of(i));
      end
    end
    nchk++;
    if ({pend_ovf, pv, pch, pdir} !== '0) begin
      nerr++;
      $display("FAIL reset_flags: got ovf=%b pv=%b ch=%0d dir=%b want 0",
               pend_ovf, pv, pch, pdir);
    end
    up[0] = 1; up[3] = 1; tick();
    faz = 1; tick();
    nchk++;
    if (pv !== 1 || pch !== 0 || pdir !== 1) begin
      nerr++;
      $display("FAIL reset_first_grant: got pv=%b ch=%0d dir=%b want 1/0/1",
               pv, pch, pdir);
    end
  endtask

  task automatic test_single_chan();
    do_reset();
    for (int k = 0; k < 3; k++) begin up[2] = 1; tick(); end
    for (int k = 0; k < 3; k++) begin
      faz = 1; tick();
      nchk++;
      if (pv !== 1 || pch !== 2 || pdir !== 1) begin
        nerr++;
        $display("FAIL single_pulse%0d: got pv=%b ch=%0d dir=%b want 1/2/1",
                 k, pv, pch, pdir);
      end
    end
    nchk++;
    if (cnt_of(2) !== 3) begin
      nerr++; $display("FAIL single_cnt: got %0d want 3", cnt_of(2));
    end
    faz = 1; tick();
    nchk++;
    if (pv !== 0) begin
      nerr++; $display("FAIL single_drained: got pv=%b want 0", pv);
    end
  endtask

  task automatic test_order();
    int exp_ch [3];
    bit exp_dir [3];
    exp_ch = '{1, 3, 0};
    exp_dir = '{1, 1, 0};
    do_reset();
    up[0] = 1; tick();
    faz = 1; tick();
    up[1] = 1; up[3] = 1; dn[0] = 1; tick();
    for (int k = 0; k < 3; k++) begin
      faz = 1; tick();
      nchk++;
      if (pv !== 1 || int'(pch) !== exp_ch[k] || pdir !== exp_dir[k]) begin
        nerr++;
        $display("FAIL order%0d: got pv=%b ch=%0d dir=%b want 1/%0d/%0d",
                 k, pv, pch, pdir, exp_ch[k], exp_dir[k]);
      end
    end
  endtask

  task automatic test_saturate();
    do_reset();
    for (int k = 0; k < 9; k++) begin up[4] = 1; tick(); end
    nchk++;
    if (cnt_of(4) !== 9 || pend_ovf[4] !== 1) begin
      nerr++;
      $display("FAIL sat_fill: got cnt=%0d ovf=%b want 9/1",
               cnt_of(4), pend_ovf[4]);
    end
    for (int k = 0; k < 7; k++) begin
      faz = 1; tick();
      nchk++;
      if (pv !== 1 || pch !== 4 || pdir !== 1) begin
        nerr++;
        $display("FAIL sat_drain%0d: got pv=%b ch=%0d dir=%b want 1/4/1",
                 k, pv, pch, pdir);
      end
    end
    faz = 1; tick();
    nchk++;
    if (pv !== 0 || pend_ovf[4] !== 1) begin
      nerr++;
      $display("FAIL sat_empty: got pv=%b ovf=%b want 0/1", pv, pend_ovf[4]);
    end
    cz[4] = 1; tick();
    nchk++;
    if (pend_ovf[4] !== 0 || cnt_of(4) !== 0) begin
      nerr++;
      $display("FAIL sat_cduz: got ovf=%b cnt=%0d want 0/0",
               pend_ovf[4], cnt_of(4));
    end
  endtask

  task automatic test_wrap();
    do_reset();
    ca[1] = 1; cav[1*W +: W] = 16'hFFFF; tick();
    nchk++;
    if (cnt_of(1) !== 'hFFFF) begin
      nerr++; $display("FAIL wrap_load: got %0h want ffff", cnt_of(1));
    end
    up[1] = 1; tick();
    nchk++;
    if (cnt_of(1) !== 0) begin
      nerr++; $display("FAIL wrap_up: got %0h want 0", cnt_of(1));
    end
    dn[1] = 1; tick();
    nchk++;
    if (cnt_of(1) !== 'hFFFF) begin
      nerr++; $display("FAIL wrap_dn: got %0h want ffff", cnt_of(1));
    end
    up[1] = 1; dn[1] = 1; tick();
    nchk++;
    if (cnt_of(1) !== 'hFFFF) begin
      nerr++; $display("FAIL wrap_both: got %0h want ffff", cnt_of(1));
    end
  endtask

  task automatic test_cduz_strobe();
    do_reset();
    up[0] = 1; tick(); up[0] = 1; tick();
    faz = 1; cz[0] = 1; tick();
    nchk++;
    if (pv !== 0 || cnt_of(0) !== 0) begin
      nerr++;
      $display("FAIL cduz_strobe: got pv=%b cnt=%0d want 0/0", pv, cnt_of(0));
    end
    faz = 1; tick();
    nchk++;
    if (pv !== 0) begin
      nerr++; $display("FAIL cduz_pend: got pv=%b want 0", pv);
    end
    up[0] = 1; tick();
    faz = 1; ca[0] = 1; cav[0 +: W] = 16'h1234; tick();
    nchk++;
    if (pv !== 0 || cnt_of(0) !== 'h1234) begin
      nerr++;
      $display("FAIL ca_strobe: got pv=%b cnt=%0h want 0/1234",
               pv, cnt_of(0));
    end
    faz = 1; tick();
    nchk++;
    if (pv !== 0) begin
      nerr++; $display("FAIL ca_pend: got pv=%b want 0", pv);
    end
  endtask

  task automatic test_err();
    do_reset();
    eec[3] = 1;
    for (int k = 0; k < 300; k++) begin pc[3] = 1; pc[2] = 1; tick(); end
    nchk++;
    if (err_of(3) !== EMAX) begin
      nerr++; $display("FAIL err_pos: got %0d want %0d", err_of(3), EMAX);
    end
    nchk++;
    if (err_of(2) !== 0) begin
      nerr++; $display("FAIL err_disabled: got %0d want 0", err_of(2));
    end
    for (int k = 0; k < 600; k++) begin mc[3] = 1; tick(); end
    pc[3] = 1; mc[3] = 1; tick();
    nchk++;
    if (err_of(3) !== -EMAX) begin
      nerr++; $display("FAIL err_neg: got %0d want %0d", err_of(3), -EMAX);
    end
    eec[3] = 0; tick();
    nchk++;
    if (err_of(3) !== 0) begin
      nerr++; $display("FAIL err_clear: got %0d want 0", err_of(3));
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    up[0] = 1; up[2] = 1; tick();
    faz = 1; tick();
    nchk++;
    if (pv !== 1) begin
      nerr++; $display("FAIL areset_pre: got pv=%b want 1", pv);
    end
    #2;
    rst = 1;
    #1;
    nchk++;
    if (pv !== 0 || cnt_of(0) !== 0) begin
      nerr++;
      $display("FAIL areset_drop: got pv=%b cnt=%0d want 0/0", pv, cnt_of(0));
    end
    model_reset();
    @(negedge clk);
    rst = 0;
    @(posedge clk);
    #1;
    faz = 1; tick();
    nchk++;
    if (pv !== 0) begin
      nerr++; $display("FAIL areset_noreplay: got pv=%b want 0", pv);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 800; c++) begin
      logic [N-1:0] a, b;
      a = N'($urandom);
      b = N'($urandom) & N'($urandom) & N'($urandom);
      up = (c < 400) ? a : b;
      dn = (c < 400) ? b : a;
      cz = N'($urandom) & N'($urandom) & N'($urandom) & N'($urandom)
         & N'($urandom);
      ca = N'($urandom) & N'($urandom) & N'($urandom) & N'($urandom)
         & N'($urandom);
      cav = {$urandom, $urandom, $urandom};
      eec = ~(N'($urandom) & N'($urandom) & N'($urandom) & N'($urandom)
            & N'($urandom) & N'($urandom));
      pc = N'($urandom);
      mc = N'($urandom);
      faz = ($urandom_range(0, 3) == 0);
      tick();
      nchk++;
      if (pv !== m_pv || int'(pch) !== m_pch || pdir !== m_pdir) begin
        nerr++;
        $display("FAIL rnd_pulse c%0d: got %b/%0d/%b want %b/%0d/%b",
                 c, pv, pch, pdir, m_pv, m_pch, m_pdir);
      end
      for (int i = 0; i < N; i++) begin
        nchk++;
        if (cnt_of(i) !== int'(m_cnt[i]) || err_of(i) !== m_err[i]
            || pend_ovf[i] !== m_ovf[i]) begin
          nerr++;
          $display("FAIL rnd_ch%0d c%0d: got %0h/%0d/%b want %0h/%0d/%b",
                   i, c, cnt_of(i), err_of(i), pend_ovf[i],
                   m_cnt[i], m_err[i], m_ovf[i]);
        end
      end
    end
  endtask

  initial begin
    rst = 1;
    clear_pulses();
    eec = '0;
    cav = '0;
    model_reset();
    #12;
    rst = 0;
    test_reset();
    test_single_chan();
    test_order();
    test_saturate();
    test_wrap();
    test_cduz_strobe();
    test_err();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
